// File: rtl/lis_pkg.sv
// Shared bus definitions for the CPU, video and memory arbiter blocks.
//   DATA_W / ADDR_W : byte-wide data bus, 32-bit byte address
//   arb_state_e     : memory arbiter state encoding (CPU / DMA / HOLD)
package lis_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 32;

   typedef enum logic [1:0] {
      S_CPU  = 2'd0,
      S_DMA  = 2'd1,
      S_HOLD = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port byte-memory arbiter between the CPU core and one DMA master.
// DMA requests win the bus with zero latency, but bursts are capped at
// DMA_BURST cycles, after which the CPU gets a forced window of CPU_SLOT
// cycles. The CPU is stalled through cpu_ce on every DMA cycle, and those
// stall cycles are counted in a saturating 16-bit counter.
//   clock, reset_n                    : clock, synchronous active-low reset
//   cpu_address/cpu_out/cpu_we        : CPU bus request
//   cpu_in, cpu_ce                    : CPU read data, CPU clock enable
//   dma_req/dma_we/dma_address/dma_wdata : DMA bus request
//   dma_ack, dma_rdata                : DMA cycle performed, DMA read data
//   mem_address/mem_d/mem_we, mem_q   : memory bus (mem_q combinational)
//   stall_clr, stall_cnt              : stall counter clear / value
module mem_arbiter
   import lis_pkg::*;
#(
   parameter int unsigned DMA_BURST = 4,
   parameter int unsigned CPU_SLOT  = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic [DATA_W-1:0] cpu_out,
   input  logic              cpu_we,
   output logic [DATA_W-1:0] cpu_in,
   output logic              cpu_ce,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_address,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_d,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_q,
   input  logic              stall_clr,
   output logic [15:0]       stall_cnt
);

   localparam logic [3:0] BURST_LAST = 4'(DMA_BURST);
   localparam logic [3:0] HOLD_LAST  = 4'(CPU_SLOT - 1);

   arb_state_e  state_q, state_d;
   logic [3:0]  bc_q, bc_d;
   logic [3:0]  hc_q, hc_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [3:0]  bc_next;
   logic        dma_grant;

   always_comb begin
      // Reset gating keeps a pending request from being acknowledged while
      // the arbiter is being reset.
      dma_grant = reset_n & dma_req & (state_q != S_HOLD);

      cpu_ce    = ~dma_grant;
      dma_ack   = dma_grant;
      cpu_in    = mem_q;
      dma_rdata = mem_q;
      if (dma_grant) begin
         mem_address = dma_address;
         mem_d       = dma_wdata;
         mem_we      = dma_we;
      end else begin
         mem_address = cpu_address;
         mem_d       = cpu_out;
         mem_we      = cpu_we;
      end

      // bc counts grants already given in this burst (0 in S_CPU), so
      // bc_next is the number including this cycle's grant; reaching
      // DMA_BURST here makes this the last DMA cycle before the CPU window.
      bc_next = bc_q + 4'd1;
      state_d = state_q;
      bc_d    = bc_q;
      hc_d    = hc_q;
      unique case (state_q)
         S_CPU, S_DMA: begin
            if (dma_grant) begin
               bc_d = bc_next;
               if (bc_next == BURST_LAST) begin
                  state_d = S_HOLD;
                  hc_d    = '0;
               end else begin
                  state_d = S_DMA;
               end
            end else begin
               state_d = S_CPU;
               bc_d    = '0;
            end
         end
         S_HOLD: begin
            hc_d = hc_q + 4'd1;
            if (hc_q == HOLD_LAST) begin
               state_d = S_CPU;
               bc_d    = '0;
               hc_d    = '0;
            end
         end
         default: begin
            state_d = S_CPU;
            bc_d    = '0;
            hc_d    = '0;
         end
      endcase

      stall_cnt_d = stall_cnt_q;
      if (stall_clr)
         stall_cnt_d = '0;
      else if (!cpu_ce && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= S_CPU;
         bc_q        <= '0;
         hc_q        <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         bc_q        <= bc_d;
         hc_q        <= hc_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single-cycle vectors, hand
// sequences for bursts / held CPU writes / reset mid-burst, and a second
// instance (DMA_BURST=15) driven by continuous DMA to reach counter saturation.
module tb_mem_arbiter;

   typedef struct {
      logic        rst_n, req, dwe, cwe, clr;
      logic [31:0] caddr, daddr;
      logic [7:0]  cout, dwd;
      logic        e_ack, e_ce, e_we;
      logic [31:0] e_addr;
      logic [7:0]  e_d;
      logic [15:0] e_stall;
      logic        chk_q;
      logic [7:0]  e_q;
   } vec_t;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   // main DUT signals
   logic        reset_n, cpu_we, dma_req, dma_we, stall_clr;
   logic [31:0] cpu_address, dma_address;
   logic [7:0]  cpu_out, dma_wdata;
   logic [7:0]  cpu_in, dma_rdata, mem_d, mem_q;
   logic        cpu_ce, dma_ack, mem_we;
   logic [31:0] mem_address;
   logic [15:0] stall_cnt;

   // saturation DUT signals
   logic        s_rst, s_req, s_clr;
   logic [7:0]  s_cpu_in, s_dma_rdata, s_mem_d;
   logic        s_ce, s_ack, s_mem_we;
   logic [31:0] s_mem_address;
   logic [15:0] s_stall;

   logic [7:0]  mem [0:65535];
   always @(posedge clock) if (mem_we) mem[mem_address[15:0]] <= mem_d;
   assign mem_q = mem[mem_address[15:0]];

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_stall;
   logic        sat_done = 1'b0;
   vec_t        sb[$];
   vec_t        tbl[9];

   mem_arbiter #(.DMA_BURST(4), .CPU_SLOT(1)) dut (
      .clock(clock), .reset_n(reset_n),
      .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we),
      .cpu_in(cpu_in), .cpu_ce(cpu_ce),
      .dma_req(dma_req), .dma_we(dma_we), .dma_address(dma_address),
      .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .mem_address(mem_address), .mem_d(mem_d), .mem_we(mem_we), .mem_q(mem_q),
      .stall_clr(stall_clr), .stall_cnt(stall_cnt)
   );

   mem_arbiter #(.DMA_BURST(15), .CPU_SLOT(1)) u_sat (
      .clock(clock), .reset_n(s_rst),
      .cpu_address(32'h0), .cpu_out(8'h00), .cpu_we(1'b0),
      .cpu_in(s_cpu_in), .cpu_ce(s_ce),
      .dma_req(s_req), .dma_we(1'b0), .dma_address(32'h4), .dma_wdata(8'h00),
      .dma_ack(s_ack), .dma_rdata(s_dma_rdata),
      .mem_address(s_mem_address), .mem_d(s_mem_d), .mem_we(s_mem_we),
      .mem_q(8'h00), .stall_clr(s_clr), .stall_cnt(s_stall)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic rst_n, req, dwe, cwe, clr,
      input logic [31:0] caddr, daddr, input logic [7:0] cout, dwd,
      input logic e_ack, e_ce, e_we, input logic [31:0] e_addr,
      input logic [7:0] e_d, input logic [15:0] e_stall,
      input logic chk_q, input logic [7:0] e_q);
      vec_t v;
      v.rst_n = rst_n; v.req = req; v.dwe = dwe; v.cwe = cwe; v.clr = clr;
      v.caddr = caddr; v.daddr = daddr; v.cout = cout; v.dwd = dwd;
      v.e_ack = e_ack; v.e_ce = e_ce; v.e_we = e_we; v.e_addr = e_addr;
      v.e_d = e_d; v.e_stall = e_stall; v.chk_q = chk_q; v.e_q = e_q;
      return v;
   endfunction

   task automatic apply(input vec_t v, input string tag);
      vec_t e;
      @(negedge clock);
      reset_n = v.rst_n; dma_req = v.req; dma_we = v.dwe; cpu_we = v.cwe;
      stall_clr = v.clr; cpu_address = v.caddr; dma_address = v.daddr;
      cpu_out = v.cout; dma_wdata = v.dwd;
      sb.push_back(v);
      #2;
      e = sb.pop_front();
      check({tag, ".ack"},   {31'd0, dma_ack}, {31'd0, e.e_ack});
      check({tag, ".ce"},    {31'd0, cpu_ce},  {31'd0, e.e_ce});
      check({tag, ".we"},    {31'd0, mem_we},  {31'd0, e.e_we});
      check({tag, ".addr"},  mem_address,      e.e_addr);
      check({tag, ".d"},     {24'd0, mem_d},   {24'd0, e.e_d});
      check({tag, ".stall"}, {16'd0, stall_cnt}, {16'd0, e.e_stall});
      if (e.chk_q) begin
         check({tag, ".cpu_in"},    {24'd0, cpu_in},    {24'd0, e.e_q});
         check({tag, ".dma_rdata"}, {24'd0, dma_rdata}, {24'd0, e.e_q});
      end
   endtask

   // One cycle of a hand sequence; bus expectations follow from who should
   // own the bus (e_ack), and the stall count is tracked alongside.
   task automatic seq_cycle(input logic rst_n, req, dwe, cwe, clr,
                            input logic [31:0] caddr, daddr,
                            input logic [7:0] cout, dwd,
                            input logic e_ack, input string tag);
      vec_t v;
      v = mk(rst_n, req, dwe, cwe, clr, caddr, daddr, cout, dwd,
             e_ack, !e_ack, e_ack ? dwe : cwe, e_ack ? daddr : caddr,
             e_ack ? dwd : cout, exp_stall, 1'b0, 8'h00);
      if (!rst_n || clr)                       exp_stall = '0;
      else if (e_ack && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      apply(v, tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // saturation run: 15 DMA cycles then 1 CPU cycle, repeating
   initial begin
      s_rst = 1'b0; s_req = 1'b0; s_clr = 1'b0;
      repeat (2) @(negedge clock);
      s_rst = 1'b1; s_req = 1'b1;
      repeat (69902) @(posedge clock);
      #1 check("sat.below", {16'd0, s_stall}, 32'd65534);
      repeat (2) @(posedge clock);
      #1 check("sat.reach", {16'd0, s_stall}, 32'hFFFF);
      repeat (40) @(posedge clock);
      #1 check("sat.hold", {16'd0, s_stall}, 32'hFFFF);
      @(negedge clock);
      s_clr = 1'b1;
      #1 check("sat.clr_cycle_ce", {31'd0, s_ce}, 32'd0);
      @(posedge clock);
      #1 s_clr = 1'b0;
      check("sat.cleared", {16'd0, s_stall}, 32'd0);
      @(posedge clock);
      #1 check("sat.recount", {16'd0, s_stall}, 32'd1);
      sat_done = 1'b1;
   end

   initial begin
      reset_n = 1'b0; dma_req = 1'b0; dma_we = 1'b0; cpu_we = 1'b0;
      stall_clr = 1'b0; cpu_address = 32'h100; dma_address = 32'h2000;
      cpu_out = 8'h00; dma_wdata = 8'h00;
      @(posedge clock);

      tbl[0] = mk(0,1,0,1,0, 32'h100,32'h2000, 8'h11,8'h00, 0,1,1,32'h100,8'h11,16'd0, 0,8'h00);
      tbl[1] = mk(1,0,0,1,0, 32'h100,32'h2000, 8'h11,8'h00, 0,1,1,32'h100,8'h11,16'd0, 0,8'h00);
      tbl[2] = mk(1,0,0,1,0, 32'h100,32'h2000, 8'h11,8'h00, 0,1,1,32'h100,8'h11,16'd0, 0,8'h00);
      tbl[3] = mk(1,1,1,1,0, 32'h100,32'h2000, 8'h11,8'hA5, 1,0,1,32'h2000,8'hA5,16'd0, 0,8'h00);
      tbl[4] = mk(1,0,0,0,0, 32'h100,32'h2000, 8'h11,8'h00, 0,1,0,32'h100,8'h11,16'd1, 1,8'h11);
      tbl[5] = mk(1,1,0,0,0, 32'h100,32'h2000, 8'h11,8'h00, 1,0,0,32'h2000,8'h00,16'd1, 1,8'hA5);
      tbl[6] = mk(1,0,0,0,0, 32'h100,32'h2000, 8'h00,8'h00, 0,1,0,32'h100,8'h00,16'd2, 1,8'h11);
      tbl[7] = mk(1,0,0,0,1, 32'h100,32'h2000, 8'h00,8'h00, 0,1,0,32'h100,8'h00,16'd2, 0,8'h00);
      tbl[8] = mk(1,0,0,0,0, 32'h100,32'h2000, 8'h00,8'h00, 0,1,0,32'h100,8'h00,16'd0, 0,8'h00);
      for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("vec%0d", i));

      exp_stall = 16'd0;
      for (int i = 0; i < 20; i++)
         seq_cycle(1,1,0,0,0, 32'h100,32'h2000, 8'h00,8'h00, (i % 5) != 4,
                   $sformatf("cont%0d", i));
      seq_cycle(1,0,0,0,0, 32'h100,32'h2000, 8'h00,8'h00, 0, "cont_end");
      check("cont.stall16", {16'd0, stall_cnt}, 32'd16);

      seq_cycle(1,1,1,1,0, 32'h10,32'h10, 8'h3C,8'h77, 1, "wh0");
      seq_cycle(1,1,1,1,0, 32'h10,32'h10, 8'h3C,8'h77, 1, "wh1");
      seq_cycle(1,0,1,1,0, 32'h10,32'h10, 8'h3C,8'h77, 0, "wh2");
      seq_cycle(1,0,0,0,0, 32'h10,32'h10, 8'h00,8'h00, 0, "wh3");
      check("wh.final_cpu_in",    {24'd0, cpu_in},    32'h3C);
      check("wh.final_dma_rdata", {24'd0, dma_rdata}, 32'h3C);

      seq_cycle(1,1,0,0,0, 32'h100,32'h2000, 8'h00,8'h00, 1, "rst_b0");
      seq_cycle(1,1,0,0,0, 32'h100,32'h2000, 8'h00,8'h00, 1, "rst_b1");
      seq_cycle(0,1,0,0,0, 32'h100,32'h2000, 8'h00,8'h00, 0, "rst_a0");
      seq_cycle(0,1,0,0,0, 32'h100,32'h2000, 8'h00,8'h00, 0, "rst_a1");
      for (int i = 0; i < 4; i++)
         seq_cycle(1,1,0,0,0, 32'h100,32'h2000, 8'h00,8'h00, 1,
                   $sformatf("rst_nb%0d", i));
      seq_cycle(1,1,0,0,0, 32'h100,32'h2000, 8'h00,8'h00, 0, "rst_hold");
      seq_cycle(1,1,0,0,0, 32'h100,32'h2000, 8'h00,8'h00, 1, "rst_again");
      seq_cycle(1,0,0,0,0, 32'h100,32'h2000, 8'h00,8'h00, 0, "rst_idle");

      wait (sat_done);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
